// File: rtl/image_scanout.sv
// VGA raster scan-out: walks the frame, addresses the frame-buffer read port and
// emits colour/hsync/vsync/de aligned to the RAM read latency.
module image_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int RD_LAT      = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [7:0] x_vga,
    output logic [6:0] y_vga,
    input  logic [2:0] dout_vga,
    output logic [2:0] vga_color,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_de,
    output logic       frame_start
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          first;
    logic          h_wrap, frame_end;

    assign h_wrap    = (h_cnt == H_LAST);
    assign frame_end = h_wrap && (v_cnt == V_LAST);

    // first marks the initial pix_en after reset, which also counts as a frame start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            first       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && (first || frame_end);
            if (pix_en) begin
                first <= 1'b0;
                h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
                if (h_wrap)
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end
        end
    end

    logic       act, hs0, vs0;
    logic [7:0] x_nxt;
    logic [6:0] y_nxt;

    always_comb begin
        act   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs0   = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs0   = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        x_nxt = act ? 8'(h_cnt >> SCALE_SHIFT) : '0;
        y_nxt = act ? 7'(v_cnt >> SCALE_SHIFT) : '0;
    end

    // Stage [0] sits alongside the address; stage [RD_LAT] lines up with dout_vga.
    logic [RD_LAT:0] de_pipe, hs_pipe, vs_pipe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_vga     <= '0;
            y_vga     <= '0;
            de_pipe   <= '0;
            hs_pipe   <= '1;
            vs_pipe   <= '1;
            vga_de    <= 1'b0;
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
            vga_color <= '0;
        end else begin
            x_vga     <= x_nxt;
            y_vga     <= y_nxt;
            de_pipe   <= {de_pipe[RD_LAT-1:0], act};
            hs_pipe   <= {hs_pipe[RD_LAT-1:0], hs0};
            vs_pipe   <= {vs_pipe[RD_LAT-1:0], vs0};
            vga_de    <= de_pipe[RD_LAT];
            vga_hs    <= hs_pipe[RD_LAT];
            vga_vs    <= vs_pipe[RD_LAT];
            vga_color <= de_pipe[RD_LAT] ? dout_vga : 3'd0;
        end
    end
endmodule

// File: tb/tb_image_scanout.sv
// Scoreboarded bench for image_scanout using small raster timing and a
// behavioural frame-buffer whose pixel value is (x+y)&7.
module tb_image_scanout;
    localparam int HT = 14, VT = 7;

    logic       clk = 0, reset = 1, pix_en = 0;
    logic [7:0] x_vga;
    logic [6:0] y_vga;
    logic [2:0] dout_vga = 0, vga_color;
    logic       vga_hs, vga_vs, vga_de, frame_start;

    image_scanout #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SCALE_SHIFT(1), .RD_LAT(1)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x_vga(x_vga), .y_vga(y_vga), .dout_vga(dout_vga),
        .vga_color(vga_color), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_de(vga_de), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) dout_vga <= 3'(x_vga + 8'(y_vga));

    typedef struct packed {
        logic [2:0] color;
        logic       hs, vs, de;
        logic [7:0] x;
        logic [6:0] y;
    } exp_t;

    exp_t out_q[$];
    logic fs_q[$];
    int   checks = 0, fails = 0;
    bit   checking = 0;
    int   mh = 0, mv = 0;
    bit   mfirst = 1;
    int   cyc = 0, last_fs = -1, last_period = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs for a raster position, straight from the display rules.
    function automatic exp_t exp_of(input int h, input int v);
        exp_t e;
        bit act;
        act     = (h < 8) && (v < 4);
        e.de    = act;
        e.x     = act ? 8'(h / 2) : 8'd0;
        e.y     = act ? 7'(v / 2) : 7'd0;
        e.color = act ? 3'((h / 2 + v / 2) % 8) : 3'd0;
        e.hs    = !(h == 10 || h == 11);
        e.vs    = (v != 5);
        return e;
    endfunction

    function automatic exp_t idle();
        exp_t e;
        e.color = 0; e.hs = 1; e.vs = 1; e.de = 0; e.x = 0; e.y = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (checking && out_q.size() >= 4) begin
            e = out_q[2];
            chk("x_vga", int'(x_vga), int'(e.x));
            chk("y_vga", int'(y_vga), int'(e.y));
            e = out_q.pop_front();
            chk("vga_color", int'(vga_color), int'(e.color));
            chk("vga_hs", int'(vga_hs), int'(e.hs));
            chk("vga_vs", int'(vga_vs), int'(e.vs));
            chk("vga_de", int'(vga_de), int'(e.de));
        end
        if (checking && fs_q.size() >= 2)
            chk("frame_start", int'(frame_start), int'(fs_q.pop_front()));
        if (frame_start) begin
            if (last_fs >= 0) last_period = cyc - last_fs;
            last_fs = cyc;
        end
    end

    // Called at posedge+1: queue expectations for the current raster position, then drive.
    task automatic step(input logic pe);
        out_q.push_back(exp_of(mh, mv));
        fs_q.push_back(pe && (mfirst || (mh == HT - 1 && mv == VT - 1)));
        pix_en = pe;
        if (pe) begin
            mfirst = 0;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else mh++;
        end
        @(posedge clk); #1;
    endtask

    task automatic release_reset();
        reset = 1;
        mh = 0; mv = 0; mfirst = 1;
        for (int i = 0; i < 3; i++) out_q.push_back(idle());
        fs_q.push_back(1'b0);
        checking = 1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_x"}, int'(x_vga), 0);
        chk({tag, "_y"}, int'(y_vga), 0);
        chk({tag, "_color"}, int'(vga_color), 0);
        chk({tag, "_hs"}, int'(vga_hs), 1);
        chk({tag, "_vs"}, int'(vga_vs), 1);
        chk({tag, "_de"}, int'(vga_de), 0);
        chk({tag, "_fs"}, int'(frame_start), 0);
    endtask

    initial begin
        #2 reset = 0;
        repeat (2) @(posedge clk);
        #1 pix_en = 1;
        @(posedge clk); #1;
        check_idle("reset");
        release_reset();

        // continuous pixel clock: three frames, last full frame is 98 clks
        for (int i = 0; i < 3 * HT * VT + 4; i++) step(1'b1);
        chk("period_full", last_period, HT * VT);

        // pix_en one cycle in two: everything stretches by 2
        for (int i = 0; i < 6 * HT * VT + 4; i++) step(1'(i % 2));
        chk("period_half", last_period, 2 * HT * VT);

        for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)));

        // reset in the middle of a frame
        for (int i = 0; i < 400 && !(mh == 5 && mv == 2); i++) step(1'b1);
        chk("reach_h5_v2", int'(mh == 5 && mv == 2), 1);
        reset = 0;
        checking = 0;
        out_q.delete();
        fs_q.delete();
        #1 check_idle("midreset");
        repeat (3) @(posedge clk);
        #1 release_reset();
        for (int i = 0; i < 2 * HT * VT + 4; i++) step(1'b1);

        checking = 0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
